fpu_sequencer: RTL and testbench

//  Sequences one FPU operation at a time between the core's execute stage and
//  the stb/ack-handshaked FPU controller. Latches the op and operands from a

---
 rtl/fpu_sequencer_if.sv | 38 +++
 rtl/fpu_sequencer.sv | 123 ++++++++++++
 tb/tb_fpu_sequencer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_sequencer_if.sv
// Bundle of the request/response ports toward the core and the stb/ack ports toward
// the FPU controller. The master modport is the sequencer; the slave modport is its environment.
interface fpu_sequencer_if;
    // req/rsp: a beat moves on a rising edge where valid && ready; the source holds its payload until then.
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_err;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_in1;
    logic [31:0] fpu_in2;
    logic        fpu_in1_stb;
    logic        fpu_in1_ack;
    logic        fpu_in2_stb;
    logic        fpu_in2_ack;
    logic [31:0] fpu_out;
    logic        fpu_out_stb;
    logic        fpu_out_ack;

    modport master (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        input  fpu_in1_ack, fpu_in2_ack, fpu_out, fpu_out_stb,
        output req_ready, rsp_valid, rsp_data, rsp_err,
        output fpu_op, fpu_in1, fpu_in2, fpu_in1_stb, fpu_in2_stb, fpu_out_ack
    );

    modport slave (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        output fpu_in1_ack, fpu_in2_ack, fpu_out, fpu_out_stb,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
        input  fpu_op, fpu_in1, fpu_in2, fpu_in1_stb, fpu_in2_stb, fpu_out_ack
    );
endinterface

// File: rtl/fpu_sequencer.sv
// Runs one FPU operation at a time: accept request, hand in1/in2 to the FPU, collect
// the result, and return it (or an illegal-op / timeout error) on the response port.
module fpu_sequencer #(
    parameter int         TIMEOUT_CYCLES = 1024,
    parameter logic [3:0] MAX_OP         = 4'd8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fpu_sequencer_if.master      bus,
    output logic [2:0]           state_dbg
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEND_A = 3'd1,
        SEND_B = 3'd2,
        WAIT_Z = 3'd3,
        RESP   = 3'd4
    } state_t;

    localparam int              CW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT_CYCLES - 2);
    localparam logic [1:0]      ERR_OK   = 2'b00;
    localparam logic [1:0]      ERR_OP   = 2'b01;
    localparam logic [1:0]      ERR_TO   = 2'b10;
    localparam logic [31:0]     QNAN     = 32'h7FC0_0000;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          xfer;

    assign state_dbg = state;

    // Only the handshake belonging to the current state can complete; stray acks are ignored.
    always_comb begin
        xfer = 1'b0;
        case (state)
            SEND_A:  xfer = bus.fpu_in1_stb && bus.fpu_in1_ack;
            SEND_B:  xfer = bus.fpu_in2_stb && bus.fpu_in2_ack;
            WAIT_Z:  xfer = bus.fpu_out_ack && bus.fpu_out_stb;
            default: xfer = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            cnt             <= '0;
            bus.req_ready   <= 1'b1;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_data    <= '0;
            bus.rsp_err     <= ERR_OK;
            bus.fpu_op      <= 4'b0000;
            bus.fpu_in1     <= '0;
            bus.fpu_in2     <= '0;
            bus.fpu_in1_stb <= 1'b0;
            bus.fpu_in2_stb <= 1'b0;
            bus.fpu_out_ack <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        bus.fpu_op    <= bus.req_op;
                        bus.fpu_in1   <= bus.req_a;
                        bus.fpu_in2   <= bus.req_b;
                        bus.req_ready <= 1'b0;
                        cnt           <= '0;
                        if (bus.req_op <= MAX_OP) begin
                            bus.fpu_in1_stb <= 1'b1;
                            state           <= SEND_A;
                        end else begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_err   <= ERR_OP;
                            bus.rsp_data  <= '0;
                            state         <= RESP;
                        end
                    end
                end
                SEND_A, SEND_B, WAIT_Z: begin
                    if (xfer) begin
                        cnt <= '0;
                        if (state == SEND_A) begin
                            bus.fpu_in1_stb <= 1'b0;
                            bus.fpu_in2_stb <= 1'b1;
                            state           <= SEND_B;
                        end else if (state == SEND_B) begin
                            bus.fpu_in2_stb <= 1'b0;
                            bus.fpu_out_ack <= 1'b1;
                            state           <= WAIT_Z;
                        end else begin
                            bus.fpu_out_ack <= 1'b0;
                            bus.rsp_valid   <= 1'b1;
                            bus.rsp_data    <= bus.fpu_out;
                            bus.rsp_err     <= ERR_OK;
                            state           <= RESP;
                        end
                    end else if (cnt == CNT_LAST) begin
                        // Counter reaches TIMEOUT_CYCLES-1 on this edge: abandon the FPU handshake.
                        cnt             <= '0;
                        bus.fpu_in1_stb <= 1'b0;
                        bus.fpu_in2_stb <= 1'b0;
                        bus.fpu_out_ack <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        bus.rsp_data    <= QNAN;
                        bus.rsp_err     <= ERR_TO;
                        state           <= RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_sequencer.sv
// Directed bench for fpu_sequencer with a small FPU controller model whose ack/result
// delays are set per step.
module tb_fpu_sequencer;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] state_dbg;

    fpu_sequencer_if bus();

    fpu_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_OP(4'd8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // FPU controller model knobs
    int          in1_delay = 0;
    int          in2_delay = 0;
    int          out_delay = 0;
    bit          out_never = 1'b0;
    logic [31:0] fpu_result = 32'h0;
    int          c1 = 0;
    int          c2 = 0;
    int          co = 0;

    always @(negedge clk) begin
        if (bus.fpu_in1_stb === 1'b1) begin
            if (c1 >= in1_delay) bus.fpu_in1_ack = 1'b1;
            else c1++;
        end else begin
            bus.fpu_in1_ack = 1'b0;
            c1 = 0;
        end
        if (bus.fpu_in2_stb === 1'b1) begin
            if (c2 >= in2_delay) bus.fpu_in2_ack = 1'b1;
            else c2++;
        end else begin
            bus.fpu_in2_ack = 1'b0;
            c2 = 0;
        end
        if (bus.fpu_out_ack === 1'b1) begin
            if (!out_never && co >= out_delay) begin
                bus.fpu_out_stb = 1'b1;
                bus.fpu_out     = fpu_result;
            end else begin
                co++;
            end
        end else begin
            bus.fpu_out_stb = 1'b0;
            bus.fpu_out     = 32'h0;
            co = 0;
        end
    end

    // Event counters observed on the active edge
    int n_in1 = 0;
    int n_in2 = 0;
    int stall1 = 0;
    int stall2 = 0;
    int any_stb = 0;
    int ack_hi = 0;

    always @(posedge clk) begin
        if (bus.fpu_in1_stb && bus.fpu_in1_ack) n_in1 <= n_in1 + 1;
        if (bus.fpu_in2_stb && bus.fpu_in2_ack) n_in2 <= n_in2 + 1;
        if (bus.fpu_in1_stb && !bus.fpu_in1_ack) stall1 <= stall1 + 1;
        if (bus.fpu_in2_stb && !bus.fpu_in2_ack) stall2 <= stall2 + 1;
        if (bus.fpu_in1_stb || bus.fpu_in2_stb) any_stb <= any_stb + 1;
        if (bus.fpu_out_ack) ack_hi <= ack_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_req(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_valid = 1'b1;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("req_accept_bound", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cyc);
        cyc = 0;
        while (bus.rsp_valid !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("rsp_valid_seen", 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic release_rsp(input string tag);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_idle_state"}, 32'(state_dbg), 32'd0);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_rsp_valid_low"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int b_in1, b_in2, b_st1, b_st2, b_any, b_ack;

        bus.req_valid = 1'b0;
        bus.req_op    = 4'h0;
        bus.req_a     = 32'h0;
        bus.req_b     = 32'h0;
        bus.rsp_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_state", 32'(state_dbg), 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'h0);
        check("rst_stbs", {29'd0, bus.fpu_in1_stb, bus.fpu_in2_stb, bus.fpu_out_ack}, 32'd0);
        check("rst_fpu_op", 32'(bus.fpu_op), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // fadd 1.0 + 2.0, FPU acks at once
        fpu_result = 32'h4040_0000;
        send_req(4'd0, 32'h3F80_0000, 32'h4000_0000);
        wait_rsp(lat);
        check("fadd_latency", 32'(lat), 32'd3);
        check("fadd_data", bus.rsp_data, 32'h4040_0000);
        check("fadd_err", 32'(bus.rsp_err), 32'd0);
        check("fadd_in1_held", bus.fpu_in1, 32'h3F80_0000);
        check("fadd_in2_held", bus.fpu_in2, 32'h4000_0000);
        check("fadd_op_held", 32'(bus.fpu_op), 32'd0);
        release_rsp("fadd");

        // Same request with delayed acks; then stall the response port
        in1_delay = 3;
        in2_delay = 5;
        b_in1 = n_in1; b_in2 = n_in2; b_st1 = stall1; b_st2 = stall2;
        send_req(4'd0, 32'h3F80_0000, 32'h4000_0000);
        wait_rsp(lat);
        check("slow_latency", 32'(lat), 32'd11);
        check("slow_in1_xfers", 32'(n_in1 - b_in1), 32'd1);
        check("slow_in2_xfers", 32'(n_in2 - b_in2), 32'd1);
        check("slow_in1_stall", 32'(stall1 - b_st1), 32'd3);
        check("slow_in2_stall", 32'(stall2 - b_st2), 32'd5);
        check("slow_data", bus.rsp_data, 32'h4040_0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("hold_rsp_data", bus.rsp_data, 32'h4040_0000);
            check("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        release_rsp("hold");
        in1_delay = 0;
        in2_delay = 0;

        // Illegal op: error on the cycle after accept, FPU never strobed
        b_any = any_stb;
        send_req(4'hF, 32'h1234_5678, 32'h9ABC_DEF0);
        check("illop_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("illop_err", 32'(bus.rsp_err), 32'd1);
        check("illop_data", bus.rsp_data, 32'h0);
        check("illop_op_latched", 32'(bus.fpu_op), 32'hF);
        release_rsp("illop");
        check("illop_no_stb", 32'(any_stb - b_any), 32'd0);

        // Highest legal op (fle 1.0 <= 2.0 -> 1)
        fpu_result = 32'h0000_0001;
        send_req(4'd8, 32'h3F80_0000, 32'h4000_0000);
        wait_rsp(lat);
        check("fle_err", 32'(bus.rsp_err), 32'd0);
        check("fle_data", bus.rsp_data, 32'h0000_0001);
        release_rsp("fle");

        // FPU never produces a result: watchdog fires in WAIT_Z
        out_never = 1'b1;
        b_ack = ack_hi;
        send_req(4'd0, 32'h3F80_0000, 32'h4000_0000);
        wait_rsp(lat);
        check("to_latency", 32'(lat), 32'd17);
        check("to_ack_cycles", 32'(ack_hi - b_ack), 32'd15);
        check("to_ack_low", 32'(bus.fpu_out_ack), 32'd0);
        check("to_err", 32'(bus.rsp_err), 32'd2);
        check("to_data", bus.rsp_data, 32'h7FC0_0000);
        release_rsp("to");

        // Reset while waiting for the result, then a clean fmul 2.0 * 3.0
        send_req(4'd2, 32'h4000_0000, 32'h4040_0000);
        repeat (2) @(negedge clk);
        check("rst_mid_in_wait_z", 32'(state_dbg), 32'd3);
        #1 reset_n = 1'b0;
        #1;
        check("rst_mid_state", 32'(state_dbg), 32'd0);
        check("rst_mid_out_ack", 32'(bus.fpu_out_ack), 32'd0);
        check("rst_mid_fpu_op", 32'(bus.fpu_op), 32'd0);
        check("rst_mid_in1", bus.fpu_in1, 32'h0);
        check("rst_mid_in2", bus.fpu_in2, 32'h0);
        check("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        out_never = 1'b0;
        fpu_result = 32'h40C0_0000;
        @(negedge clk);
        send_req(4'd2, 32'h4000_0000, 32'h4040_0000);
        wait_rsp(lat);
        check("fmul_latency", 32'(lat), 32'd3);
        check("fmul_data", bus.rsp_data, 32'h40C0_0000);
        check("fmul_err", 32'(bus.rsp_err), 32'd0);
        release_rsp("fmul");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
